// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline tracker. Holds one {valid, rd_en, rd, is_load}
// entry per in-flight stage. It picks operand forwarding sources, detects
// load-use hazards, and applies hold and jump-flush rules. It also keeps
// retire and stall counters.
module pipe_ctrl #(
  parameter int STAGES     = 3,
  parameter int RAW        = 5,
  parameter int LOAD_STAGE = 2,
  parameter int JUMP_STAGE = 1,
  parameter int CW         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_dec_valid,
  output logic                         o_dec_ready,
  input  logic                         i_dec_rs1_en,
  input  logic                         i_dec_rs2_en,
  input  logic [RAW-1:0]               i_dec_rs1,
  input  logic [RAW-1:0]               i_dec_rs2,
  input  logic                         i_dec_rd_en,
  input  logic [RAW-1:0]               i_dec_rd,
  input  logic                         i_dec_is_load,
  input  logic                         i_hold,
  input  logic                         i_jump_valid,
  output logic                         o_flush,
  output logic [STAGES-1:0]            o_stage_valid,
  output logic [$clog2(STAGES+1)-1:0]  o_fwd1_sel,
  output logic [$clog2(STAGES+1)-1:0]  o_fwd2_sel,
  output logic                         o_retire_valid,
  output logic [RAW-1:0]               o_retire_rd,
  output logic [CW-1:0]                o_retire_cnt,
  output logic [CW-1:0]                o_stall_cnt
);

  localparam int SW = $clog2(STAGES + 1);
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0]          vld_q, vld_d;
  logic [STAGES-1:0]          rden_q, rden_d;
  logic [STAGES-1:0]          ld_q, ld_d;
  logic [STAGES-1:0][RAW-1:0] rd_q, rd_d;

  logic                       ret_vld_q;
  logic [RAW-1:0]             ret_rd_q;
  logic [CW-1:0]              ret_cnt_q;
  logic [CW-1:0]              stall_cnt_q;

  logic [STAGES-1:0]          hit1_s, hit2_s;
  logic [SW-1:0]              sel1_s, sel2_s;
  logic                       haz1_s, haz2_s;
  logic                       issue_s;
  logic                       retire_s;
  logic                       stall_s;

  // Per-stage source match; x0 and disabled sources never match.
  always_comb begin
    hit1_s = '0;
    hit2_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      hit1_s[k] = i_dec_rs1_en && (i_dec_rs1 != '0) && vld_q[k] && rden_q[k] && (rd_q[k] == i_dec_rs1);
      hit2_s[k] = i_dec_rs2_en && (i_dec_rs2 != '0) && vld_q[k] && rden_q[k] && (rd_q[k] == i_dec_rs2);
    end
  end

  // Youngest match wins: scan oldest-to-youngest so the lowest stage overrides.
  always_comb begin
    sel1_s = '0;
    sel2_s = '0;
    haz1_s = 1'b0;
    haz2_s = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      haz1_s = hit1_s[k] ? (ld_q[k] && (k < LOAD_STAGE)) : haz1_s;
      sel1_s = hit1_s[k] ? ((ld_q[k] && (k < LOAD_STAGE)) ? '0 : SW'(k + 1)) : sel1_s;
      haz2_s = hit2_s[k] ? (ld_q[k] && (k < LOAD_STAGE)) : haz2_s;
      sel2_s = hit2_s[k] ? ((ld_q[k] && (k < LOAD_STAGE)) ? '0 : SW'(k + 1)) : sel2_s;
    end
  end

  assign o_dec_ready = !haz1_s && !haz2_s && !i_hold && !i_jump_valid;
  assign o_flush     = i_jump_valid;
  assign o_fwd1_sel  = sel1_s;
  assign o_fwd2_sel  = sel2_s;
  assign issue_s     = i_dec_valid && o_dec_ready;
  assign retire_s    = vld_q[LAST] && !i_hold;
  assign stall_s     = i_dec_valid && !o_dec_ready;

  // Stage advance: shift on !hold, freeze on hold; jumps flush the younger stages.
  always_comb begin
    vld_d  = vld_q;
    rden_d = rden_q;
    ld_d   = ld_q;
    rd_d   = rd_q;
    if (!i_hold) begin
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k]  = vld_q[k-1];
        rden_d[k] = rden_q[k-1];
        ld_d[k]   = ld_q[k-1];
        rd_d[k]   = rd_q[k-1];
      end
      vld_d[0]  = issue_s;
      rden_d[0] = issue_s && i_dec_rd_en;
      ld_d[0]   = issue_s && i_dec_is_load;
      rd_d[0]   = issue_s ? i_dec_rd : '0;
    end else begin
      vld_d = vld_q;
    end
    // With the pipe moving, the jumping entry leaves a bubble behind it.
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = (i_jump_valid && ((k < JUMP_STAGE) || ((k == JUMP_STAGE) && !i_hold))) ? 1'b0 : vld_d[k];
    end
  end

  // Stage entries, retire pulse and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      rden_q      <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      ret_vld_q   <= 1'b0;
      ret_rd_q    <= '0;
      ret_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      rden_q      <= rden_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      ret_vld_q   <= retire_s;
      ret_rd_q    <= (retire_s && rden_q[LAST]) ? rd_q[LAST] : '0;
      ret_cnt_q   <= ret_cnt_q + CW'(retire_s);
      stall_cnt_q <= stall_cnt_q + CW'(stall_s);
    end
  end

  assign o_stage_valid  = vld_q;
  assign o_retire_valid = ret_vld_q;
  assign o_retire_rd    = ret_rd_q;
  assign o_retire_cnt   = ret_cnt_q;
  assign o_stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic against a
// behavioural stage-list model. A second instance with 4-bit counters
// covers counter wrap.
module tb_pipe_ctrl;
  localparam int S   = 3;
  localparam int RAW = 5;
  localparam int LS  = 2;
  localparam int JS  = 1;
  localparam int SW  = $clog2(S + 1);

  logic clk = 1'b0;
  logic rst;
  logic i_dec_valid, i_dec_rs1_en, i_dec_rs2_en, i_dec_rd_en, i_dec_is_load, i_hold, i_jump_valid;
  logic [RAW-1:0] i_dec_rs1, i_dec_rs2, i_dec_rd;
  logic o_dec_ready, o_flush, o_retire_valid;
  logic [S-1:0] o_stage_valid;
  logic [SW-1:0] o_fwd1_sel, o_fwd2_sel;
  logic [RAW-1:0] o_retire_rd;
  logic [31:0] o_retire_cnt, o_stall_cnt;
  logic w_ready, w_flush, w_rv;
  logic [S-1:0] w_sv;
  logic [SW-1:0] w_f1, w_f2;
  logic [RAW-1:0] w_rrd;
  logic [3:0] w_rc, w_sc;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(S), .RAW(RAW), .LOAD_STAGE(LS), .JUMP_STAGE(JS), .CW(32)) dut (
    .clk(clk), .rst(rst), .i_dec_valid(i_dec_valid), .o_dec_ready(o_dec_ready),
    .i_dec_rs1_en(i_dec_rs1_en), .i_dec_rs2_en(i_dec_rs2_en), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
    .i_dec_rd_en(i_dec_rd_en), .i_dec_rd(i_dec_rd), .i_dec_is_load(i_dec_is_load), .i_hold(i_hold),
    .i_jump_valid(i_jump_valid), .o_flush(o_flush), .o_stage_valid(o_stage_valid),
    .o_fwd1_sel(o_fwd1_sel), .o_fwd2_sel(o_fwd2_sel), .o_retire_valid(o_retire_valid),
    .o_retire_rd(o_retire_rd), .o_retire_cnt(o_retire_cnt), .o_stall_cnt(o_stall_cnt));

  pipe_ctrl #(.STAGES(S), .RAW(RAW), .LOAD_STAGE(LS), .JUMP_STAGE(JS), .CW(4)) dut_w (
    .clk(clk), .rst(rst), .i_dec_valid(i_dec_valid), .o_dec_ready(w_ready),
    .i_dec_rs1_en(i_dec_rs1_en), .i_dec_rs2_en(i_dec_rs2_en), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
    .i_dec_rd_en(i_dec_rd_en), .i_dec_rd(i_dec_rd), .i_dec_is_load(i_dec_is_load), .i_hold(i_hold),
    .i_jump_valid(i_jump_valid), .o_flush(w_flush), .o_stage_valid(w_sv),
    .o_fwd1_sel(w_f1), .o_fwd2_sel(w_f2), .o_retire_valid(w_rv),
    .o_retire_rd(w_rrd), .o_retire_cnt(w_rc), .o_stall_cnt(w_sc));

  // Reference model: a list of in-flight instructions indexed by age (0 = youngest).
  typedef struct { bit v; bit rden; bit [RAW-1:0] rd; bit ld; } ent_t;
  ent_t ms[S];
  int unsigned m_ret, m_stall;
  bit m_rv;
  bit [RAW-1:0] m_rrd;
  bit e_haz1, e_haz2, e_rdy;
  bit [SW-1:0] e_sel1, e_sel2;
  int n_chk = 0;
  int n_fail = 0;

  function automatic void model_src(input bit en, input bit [RAW-1:0] src, output bit haz, output bit [SW-1:0] sel);
    bit found = 1'b0;
    haz = 1'b0;
    sel = '0;
    for (int s = 0; s < S; s++) begin
      if (!found && en && src != 0 && ms[s].v && ms[s].rden && ms[s].rd == src) begin
        found = 1'b1;
        haz = ms[s].ld && (s < LS);
        sel = haz ? SW'(0) : SW'(s + 1);
      end
    end
  endfunction

  function automatic void model_comb();
    model_src(i_dec_rs1_en, i_dec_rs1, e_haz1, e_sel1);
    model_src(i_dec_rs2_en, i_dec_rs2, e_haz2, e_sel2);
    e_rdy = !e_haz1 && !e_haz2 && !i_hold && !i_jump_valid;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < S; s++) ms[s] = '{v: 1'b0, rden: 1'b0, rd: '0, ld: 1'b0};
    m_ret = 0; m_stall = 0; m_rv = 1'b0; m_rrd = '0;
  endfunction

  function automatic void model_edge();
    ent_t nx[S];
    bit ret;
    ret = ms[S-1].v && !i_hold;
    m_rv = ret;
    m_rrd = (ret && ms[S-1].rden) ? ms[S-1].rd : '0;
    if (ret) m_ret++;
    if (i_dec_valid && !e_rdy) m_stall++;
    nx = ms;
    if (!i_hold) begin
      for (int s = S - 1; s > 0; s--) nx[s] = ms[s-1];
      nx[0] = '{v: i_dec_valid && e_rdy, rden: i_dec_rd_en, rd: i_dec_rd, ld: i_dec_is_load};
    end
    if (i_jump_valid)
      for (int s = 0; s < S; s++) if (s < JS || (s == JS && !i_hold)) nx[s].v = 1'b0;
    ms = nx;
  endfunction

  function automatic bit [S-1:0] exp_sv();
    bit [S-1:0] v;
    for (int s = 0; s < S; s++) v[s] = ms[s].v;
    return v;
  endfunction

  task automatic tick();
    model_comb();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    i_dec_valid = 0; i_dec_rs1_en = 0; i_dec_rs2_en = 0; i_dec_rd_en = 0; i_dec_is_load = 0;
    i_hold = 0; i_jump_valid = 0; i_dec_rs1 = '0; i_dec_rs2 = '0; i_dec_rd = '0;
  endtask

  task automatic issue(input bit [RAW-1:0] rd, input bit ld);
    clear_inputs();
    i_dec_valid = 1; i_dec_rd_en = 1; i_dec_rd = rd; i_dec_is_load = ld;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); model_reset();
    repeat (2) tick();
    n_chk++; if (o_stage_valid !== 3'b000) begin n_fail++; $display("FAIL reset_stage_valid: got %b exp 000", o_stage_valid); end
    n_chk++; if (o_retire_valid !== 1'b0 || o_retire_rd !== 5'd0) begin n_fail++; $display("FAIL reset_retire: got %b/%0d exp 0/0", o_retire_valid, o_retire_rd); end
    n_chk++; if (o_retire_cnt !== 32'd0 || o_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", o_retire_cnt, o_stall_cnt); end
    n_chk++; if (o_dec_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", o_dec_ready); end
    rst = 0;
    issue(5'd9, 1'b0);
    n_chk++; if (o_stage_valid !== 3'b001) begin n_fail++; $display("FAIL first_issue: got %b exp 001", o_stage_valid); end
    clear_inputs();
    repeat (3) tick();
    n_chk++; if (o_retire_cnt !== 32'd1 || o_retire_valid !== 1'b1 || o_retire_rd !== 5'd9) begin
      n_fail++; $display("FAIL first_retire: got cnt %0d v %b rd %0d exp 1 1 9", o_retire_cnt, o_retire_valid, o_retire_rd); end
  endtask

  task automatic test_alu_raw();
    int unsigned base = m_ret, sbase = m_stall;
    issue(5'd5, 1'b0);
    clear_inputs(); i_dec_valid = 1; i_dec_rs1_en = 1; i_dec_rs1 = 5'd5; #1;
    n_chk++; if (o_fwd1_sel !== 2'd1 || o_dec_ready !== 1'b1) begin n_fail++; $display("FAIL alu_raw_fwd: got sel %0d rdy %b exp 1 1", o_fwd1_sel, o_dec_ready); end
    tick(); clear_inputs(); repeat (4) tick();
    n_chk++; if (o_retire_cnt !== base + 2 || o_stall_cnt !== sbase) begin
      n_fail++; $display("FAIL alu_raw_cnt: got %0d/%0d exp %0d/%0d", o_retire_cnt, o_stall_cnt, base + 2, sbase); end
  endtask

  task automatic test_load_use();
    int unsigned sbase = m_stall;
    issue(5'd7, 1'b1);
    clear_inputs(); i_dec_valid = 1; i_dec_rs2_en = 1; i_dec_rs2 = 5'd7; #1;
    n_chk++; if (o_dec_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_stall1: got %b exp 0", o_dec_ready); end
    tick();
    n_chk++; if (o_dec_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_stall2: got %b exp 0", o_dec_ready); end
    tick();
    n_chk++; if (o_dec_ready !== 1'b1 || o_fwd2_sel !== 2'd3) begin n_fail++; $display("FAIL load_use_fwd: got rdy %b sel %0d exp 1 3", o_dec_ready, o_fwd2_sel); end
    tick();
    n_chk++; if (o_stall_cnt !== sbase + 2) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d exp %0d", o_stall_cnt, sbase + 2); end
    clear_inputs(); repeat (4) tick();
  endtask

  task automatic test_x0_priority();
    issue(5'd3, 1'b0);
    clear_inputs(); tick();
    issue(5'd0, 1'b0);
    clear_inputs(); i_dec_rs1_en = 1; i_dec_rs1 = 5'd3; i_dec_rs2_en = 1; i_dec_rs2 = 5'd0; #1;
    n_chk++; if (o_fwd1_sel !== 2'd3 || o_fwd2_sel !== 2'd0) begin n_fail++; $display("FAIL x0_fwd: got %0d/%0d exp 3/0", o_fwd1_sel, o_fwd2_sel); end
    clear_inputs(); repeat (3) tick();
    issue(5'd3, 1'b0);
    issue(5'd3, 1'b0);
    clear_inputs(); i_dec_rs1_en = 1; i_dec_rs1 = 5'd3; #1;
    n_chk++; if (o_fwd1_sel !== 2'd1) begin n_fail++; $display("FAIL youngest_fwd: got %0d exp 1", o_fwd1_sel); end
    clear_inputs(); repeat (4) tick();
  endtask

  task automatic test_jump_flush();
    issue(5'd1, 1'b0); issue(5'd2, 1'b0); issue(5'd3, 1'b0);
    clear_inputs(); i_dec_valid = 1; i_dec_rd_en = 1; i_dec_rd = 5'd4; i_jump_valid = 1; #1;
    n_chk++; if (o_dec_ready !== 1'b0 || o_flush !== 1'b1) begin n_fail++; $display("FAIL jump_ready: got rdy %b flush %b exp 0 1", o_dec_ready, o_flush); end
    tick();
    n_chk++; if (o_stage_valid !== 3'b100 || o_retire_rd !== 5'd1) begin n_fail++; $display("FAIL jump_flush: got %b rd %0d exp 100 1", o_stage_valid, o_retire_rd); end
    clear_inputs(); tick();
    n_chk++; if (o_retire_valid !== 1'b1 || o_retire_rd !== 5'd2) begin n_fail++; $display("FAIL jump_retire: got %b rd %0d exp 1 2", o_retire_valid, o_retire_rd); end
    tick();
    n_chk++; if (o_retire_valid !== 1'b0 || o_stage_valid !== 3'b000) begin n_fail++; $display("FAIL jump_drain: got %b %b exp 0 000", o_retire_valid, o_stage_valid); end
  endtask

  task automatic test_hold_jump_reset();
    int unsigned base;
    issue(5'd1, 1'b0); issue(5'd2, 1'b0); issue(5'd3, 1'b0);
    base = m_ret;
    clear_inputs(); i_hold = 1; i_dec_valid = 1; i_dec_rd_en = 1; i_dec_rd = 5'd4; #1;
    n_chk++; if (o_dec_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready: got %b exp 0", o_dec_ready); end
    tick();
    n_chk++; if (o_stage_valid !== 3'b111 || o_retire_valid !== 1'b0) begin n_fail++; $display("FAIL hold_freeze: got %b %b exp 111 0", o_stage_valid, o_retire_valid); end
    i_jump_valid = 1; tick();
    n_chk++; if (o_stage_valid !== 3'b110 || o_retire_valid !== 1'b0) begin n_fail++; $display("FAIL hold_jump: got %b %b exp 110 0", o_stage_valid, o_retire_valid); end
    i_jump_valid = 0; tick();
    n_chk++; if (o_stage_valid !== 3'b110 || o_retire_cnt !== base) begin n_fail++; $display("FAIL hold_end: got %b %0d exp 110 %0d", o_stage_valid, o_retire_cnt, base); end
    clear_inputs(); rst = 1; model_reset(); #1;
    n_chk++; if (o_stage_valid !== 3'b000 || o_retire_cnt !== 32'd0 || o_stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: got %b %0d %0d exp 000 0 0", o_stage_valid, o_retire_cnt, o_stall_cnt); end
    tick(); rst = 0; tick();
    n_chk++; if (o_retire_valid !== 1'b0 || o_retire_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_discard: got %b %0d exp 0 0", o_retire_valid, o_retire_cnt); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) issue(RAW'($urandom_range(1, 31)), 1'b0);
    clear_inputs(); repeat (3) tick();
    n_chk++; if (w_rc !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d exp 1", w_rc); end
    n_chk++; if (o_retire_cnt !== 32'd17) begin n_fail++; $display("FAIL wide_cnt: got %0d exp 17", o_retire_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      i_dec_valid   = ($urandom_range(0, 99) < 80);
      i_dec_rs1_en  = ($urandom_range(0, 99) < 70);
      i_dec_rs2_en  = ($urandom_range(0, 99) < 70);
      i_dec_rd_en   = ($urandom_range(0, 99) < 80);
      i_dec_is_load = ($urandom_range(0, 99) < 30);
      i_hold        = ($urandom_range(0, 99) < 15);
      i_jump_valid  = ($urandom_range(0, 99) < 10);
      i_dec_rs1 = RAW'($urandom_range(0, 3));
      i_dec_rs2 = RAW'($urandom_range(0, 3));
      i_dec_rd  = RAW'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin rst = 1; model_reset(); end else rst = 0;
      #1; model_comb();
      n_chk++; if (o_dec_ready !== e_rdy || w_ready !== e_rdy || o_flush !== i_jump_valid || w_flush !== i_jump_valid) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b/%b flush %b exp %b flush %b", i, o_dec_ready, w_ready, o_flush, e_rdy, i_jump_valid); end
      n_chk++; if ((!e_haz1 && (o_fwd1_sel !== e_sel1 || w_f1 !== e_sel1)) || (!e_haz2 && (o_fwd2_sel !== e_sel2 || w_f2 !== e_sel2))) begin
        n_fail++; $display("FAIL rnd_fwd[%0d]: got %0d/%0d exp %0d/%0d", i, o_fwd1_sel, o_fwd2_sel, e_sel1, e_sel2); end
      tick();
      n_chk++; if (o_stage_valid !== exp_sv() || w_sv !== exp_sv()) begin n_fail++; $display("FAIL rnd_stage[%0d]: got %b exp %b", i, o_stage_valid, exp_sv()); end
      n_chk++; if (o_retire_valid !== m_rv || o_retire_rd !== m_rrd || w_rv !== m_rv || w_rrd !== m_rrd) begin
        n_fail++; $display("FAIL rnd_retire[%0d]: got %b rd %0d exp %b rd %0d", i, o_retire_valid, o_retire_rd, m_rv, m_rrd); end
      n_chk++; if (o_retire_cnt !== m_ret || o_stall_cnt !== m_stall || w_rc !== 4'(m_ret) || w_sc !== 4'(m_stall)) begin
        n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d w %0d/%0d exp %0d/%0d", i, o_retire_cnt, o_stall_cnt, w_rc, w_sc, m_ret, m_stall); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_alu_raw();
    test_load_use();
    test_x0_priority();
    test_jump_flush();
    test_hold_jump_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
